int_arbiter: RTL and testbench

Priority interrupt arbiter between the iopage device register blocks (line clock, console, disk) and the CPU's trap/interrupt sequencer. Collects per-device `interrupt`/`vector` pairs, selects the highest-priority request whose level exceeds the current processor priority, and presents one latched vector to the CPU. It routes the CPU's acknowledge back to exactly the winning device.

---
 rtl/pdp11_int_pkg.sv | 18 +
 rtl/int_pri_enc.sv | 29 ++
 rtl/int_arbiter.sv | 123 ++++++++++++
 tb/tb_int_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pdp11_int_pkg.sv
// rtl/pdp11_int_pkg.sv - shared interrupt arbitration types, widths and standard vectors
package pdp11_int_pkg;

  localparam int IPL_W = 3;
  localparam int VEC_W = 8;

  localparam logic [VEC_W-1:0] VEC_CLOCK   = 8'o100;
  localparam logic [VEC_W-1:0] VEC_CONS_RX = 8'o060;
  localparam logic [VEC_W-1:0] VEC_CONS_TX = 8'o064;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ACK  = 2'd2,
    ST_HOLD = 2'd3
  } int_state_e;

endpackage

// File: rtl/int_pri_enc.sv
// rtl/int_pri_enc.sv - combinational highest-level priority encoder, lowest index wins ties
module int_pri_enc
  import pdp11_int_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]       elig_i,
  input  logic [N*IPL_W-1:0] ipl_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic [IPL_W-1:0]   ipl_o
);

  // Strict greater-than keeps the earlier (lower) index on equal levels.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    ipl_o = '0;
    for (int i = 0; i < N; i++) begin
      if (elig_i[i] && (!any_o || (ipl_i[i*IPL_W +: IPL_W] > ipl_o))) begin
        any_o = 1'b1;
        idx_o = IDX_W'(i);
        ipl_o = ipl_i[i*IPL_W +: IPL_W];
      end
    end
  end

endmodule

// File: rtl/int_arbiter.sv
// rtl/int_arbiter.sv - priority interrupt arbiter between iopage devices and the CPU
module int_arbiter
  import pdp11_int_pkg::*;
#(
  parameter int N_SRC   = 4,
  parameter int HOLDOFF = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_SRC-1:0]         dev_int,
  input  logic [VEC_W*N_SRC-1:0]   dev_vector,
  input  logic [IPL_W*N_SRC-1:0]   dev_ipl,
  input  logic [IPL_W-1:0]         cpu_ipl,
  input  logic                     cpu_int_ack,
  output logic [N_SRC-1:0]         dev_int_ack,
  output logic                     cpu_int,
  output logic [VEC_W-1:0]         cpu_vector,
  output logic [IPL_W-1:0]         cpu_int_ipl
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0] elig;
  logic             any_elig;
  logic [IDX_W-1:0] win_idx;
  logic [IPL_W-1:0] win_ipl;
  logic [VEC_W-1:0] win_vec;
  logic             withdraw_d;

  int_state_e       state_q;
  logic [IDX_W-1:0] src_q;
  logic [VEC_W-1:0] vec_q;
  logic [IPL_W-1:0] lvl_q;
  logic [1:0]       hold_q;
  logic             req_q;
  logic [N_SRC-1:0] ack_q;

  // ipl 0 can never exceed an unsigned cpu_ipl, so it is masked for free.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_SRC; i++) begin
      elig[i] = dev_int[i] && (dev_ipl[i*IPL_W +: IPL_W] > cpu_ipl);
    end
  end

  int_pri_enc #(
    .N     (N_SRC),
    .IDX_W (IDX_W)
  ) u_pri_enc (
    .elig_i (elig),
    .ipl_i  (dev_ipl),
    .any_o  (any_elig),
    .idx_o  (win_idx),
    .ipl_o  (win_ipl)
  );

  always_comb begin
    win_vec = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (win_idx == IDX_W'(i)) win_vec = dev_vector[i*VEC_W +: VEC_W];
    end
  end

  assign withdraw_d = !dev_int[src_q] || (cpu_ipl >= lvl_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      vec_q   <= '0;
      lvl_q   <= '0;
      hold_q  <= '0;
      req_q   <= 1'b0;
      ack_q   <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (any_elig) begin
            state_q <= ST_PEND;
            src_q   <= win_idx;
            vec_q   <= win_vec;
            lvl_q   <= win_ipl;
            req_q   <= 1'b1;
          end
        end
        ST_PEND: begin
          // Acknowledge beats a same-cycle withdrawal: the CPU has already committed.
          if (cpu_int_ack) begin
            state_q <= ST_ACK;
            req_q   <= 1'b0;
            ack_q   <= N_SRC'(1) << src_q;
          end else if (withdraw_d) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            vec_q   <= '0;
            lvl_q   <= '0;
          end
        end
        ST_ACK: begin
          state_q <= ST_HOLD;
          hold_q  <= 2'(HOLDOFF - 1);
        end
        ST_HOLD: begin
          if (hold_q == 2'd0) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            lvl_q   <= '0;
          end else begin
            hold_q <= hold_q - 2'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cpu_int     = req_q;
  assign cpu_vector  = vec_q;
  assign cpu_int_ipl = lvl_q;
  assign dev_int_ack = ack_q;

endmodule

// File: tb/tb_int_arbiter.sv
// tb/tb_int_arbiter.sv - directed self-checking bench for int_arbiter
module tb_int_arbiter;

  localparam int N   = 4;
  localparam int HO  = 1;

  logic           clk;
  logic           reset;
  logic [N-1:0]   dev_int;
  logic [8*N-1:0] dev_vector;
  logic [3*N-1:0] dev_ipl;
  logic [2:0]     cpu_ipl;
  logic           cpu_int_ack;
  logic [N-1:0]   dev_int_ack;
  logic           cpu_int;
  logic [7:0]     cpu_vector;
  logic [2:0]     cpu_int_ipl;

  int n_vec = 0;
  int n_err = 0;

  int_arbiter #(.N_SRC(N), .HOLDOFF(HO)) dut (
    .clk         (clk),
    .reset       (reset),
    .dev_int     (dev_int),
    .dev_vector  (dev_vector),
    .dev_ipl     (dev_ipl),
    .cpu_ipl     (cpu_ipl),
    .cpu_int_ack (cpu_int_ack),
    .dev_int_ack (dev_int_ack),
    .cpu_int     (cpu_int),
    .cpu_vector  (cpu_vector),
    .cpu_int_ipl (cpu_int_ipl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: an outstanding request, a post-acknowledge cooldown in cycles,
  // and a priority scan over the request table.
  bit           chk_en = 1'b0;
  bit           e_int;
  logic [7:0]   e_vec;
  logic [2:0]   e_ipl;
  logic [N-1:0] e_ack;
  int           m_win;
  int           m_cool;

  always @(posedge clk) begin
    if (!reset) begin
      chk_en = 1'b1;
      e_int = 1'b0; e_vec = '0; e_ipl = '0; e_ack = '0;
      m_win = 0; m_cool = 0;
    end else if (m_cool > 0) begin
      m_cool = m_cool - 1;
      e_ack = '0;
      if (m_cool == 0) begin
        e_vec = '0;
        e_ipl = '0;
      end
    end else if (e_int) begin
      if (cpu_int_ack) begin
        e_int = 1'b0;
        e_ack = '0;
        e_ack[m_win] = 1'b1;
        m_cool = 1 + HO;
      end else if (!dev_int[m_win] || cpu_ipl >= e_ipl) begin
        e_int = 1'b0; e_vec = '0; e_ipl = '0;
      end
    end else begin
      int best;
      int best_lvl;
      best = -1;
      best_lvl = -1;
      for (int i = 0; i < N; i++) begin
        if (dev_int[i] && dev_ipl[i*3 +: 3] > cpu_ipl && int'(dev_ipl[i*3 +: 3]) > best_lvl) begin
          best = i;
          best_lvl = int'(dev_ipl[i*3 +: 3]);
        end
      end
      if (best >= 0) begin
        e_int = 1'b1;
        m_win = best;
        e_vec = dev_vector[best*8 +: 8];
        e_ipl = dev_ipl[best*3 +: 3];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if (cpu_int !== e_int || cpu_vector !== e_vec || cpu_int_ipl !== e_ipl || dev_int_ack !== e_ack) begin
        n_err++;
        $display("FAIL model_cmp t=%0t got int=%b vec=%o ipl=%0d ack=%b required int=%b vec=%o ipl=%0d ack=%b",
                 $time, cpu_int, cpu_vector, cpu_int_ipl, dev_int_ack, e_int, e_vec, e_ipl, e_ack);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic set_dev(input int i, input bit rq, input logic [2:0] lvl, input logic [7:0] vec);
    dev_int[i] = rq;
    dev_ipl[i*3 +: 3] = lvl;
    dev_vector[i*8 +: 8] = vec;
  endtask

  // Acknowledge the presented request, check the pulse, then wait back to IDLE.
  task automatic ack_and_drop(input string name, input int i);
    logic [N-1:0] oh;
    oh = '0;
    oh[i] = 1'b1;
    cpu_int_ack = 1'b1;
    cyc(1);
    lit({name, "_ack"}, 32'(dev_int_ack), 32'(oh));
    lit({name, "_ack_int"}, 32'(cpu_int), 32'd0);
    cpu_int_ack = 1'b0;
    dev_int[i] = 1'b0;
    cyc(2);
  endtask

  initial begin
    reset = 1'b0; dev_int = '0; dev_vector = '0; dev_ipl = '0;
    cpu_ipl = 3'd0; cpu_int_ack = 1'b0;
    cyc(3);
    lit("rst_int", 32'(cpu_int), 32'd0);
    lit("rst_vec", 32'(cpu_vector), 32'd0);
    lit("rst_ack", 32'(dev_int_ack), 32'd0);
    reset = 1'b1;
    cyc(1);

    // single source
    set_dev(0, 1'b1, 3'd6, 8'o100);
    cyc(1);
    lit("single_int", 32'(cpu_int), 32'd1);
    lit("single_vec", 32'(cpu_vector), 32'o100);
    lit("single_ipl", 32'(cpu_int_ipl), 32'd6);
    cyc(3);
    cpu_int_ack = 1'b1;
    cyc(1);
    lit("single_ack", 32'(dev_int_ack), 32'b0001);
    cpu_int_ack = 1'b0;
    dev_int[0] = 1'b0;
    cyc(1);
    lit("single_ack_once", 32'(dev_int_ack), 32'd0);
    lit("single_hold_vec", 32'(cpu_vector), 32'o100);
    cyc(1);
    lit("single_idle_vec", 32'(cpu_vector), 32'd0);

    // level priority, then the loser is served after the holdoff
    set_dev(1, 1'b1, 3'd4, 8'o060);
    set_dev(2, 1'b1, 3'd6, 8'o064);
    cyc(1);
    lit("pri_vec", 32'(cpu_vector), 32'o064);
    ack_and_drop("pri2", 2);
    cyc(1);
    lit("pri_next_vec", 32'(cpu_vector), 32'o060);
    lit("pri_next_ipl", 32'(cpu_int_ipl), 32'd4);
    ack_and_drop("pri1", 1);

    // equal level tie goes to lowest index
    set_dev(0, 1'b1, 3'd5, 8'o100);
    set_dev(3, 1'b1, 3'd5, 8'o070);
    cyc(1);
    lit("tie_vec", 32'(cpu_vector), 32'o100);
    ack_and_drop("tie0", 0);
    cyc(1);
    lit("tie_next_vec", 32'(cpu_vector), 32'o070);
    ack_and_drop("tie3", 3);

    // masking, withdrawal and re-presentation
    cpu_ipl = 3'd6;
    set_dev(0, 1'b1, 3'd6, 8'o100);
    cyc(2);
    lit("mask_int", 32'(cpu_int), 32'd0);
    cpu_ipl = 3'd5;
    cyc(1);
    lit("unmask_int", 32'(cpu_int), 32'd1);
    cpu_ipl = 3'd7;
    cyc(1);
    lit("withdraw_int", 32'(cpu_int), 32'd0);
    lit("withdraw_ack", 32'(dev_int_ack), 32'd0);
    cyc(2);
    cpu_ipl = 3'd0;
    cyc(1);
    lit("represent_int", 32'(cpu_int), 32'd1);

    // ack and drop in the same cycle: ack wins
    cpu_int_ack = 1'b1;
    dev_int[0] = 1'b0;
    cyc(1);
    lit("collide_ack", 32'(dev_int_ack), 32'b0001);
    cpu_int_ack = 1'b0;
    cyc(2);

    // stray ack in IDLE
    cpu_int_ack = 1'b1;
    cyc(2);
    lit("stray_ack", 32'(dev_int_ack), 32'd0);
    cpu_int_ack = 1'b0;

    // no preemption of a pending request
    set_dev(1, 1'b1, 3'd4, 8'o060);
    cyc(1);
    lit("nopre_vec0", 32'(cpu_vector), 32'o060);
    set_dev(2, 1'b1, 3'd7, 8'o064);
    cyc(2);
    lit("nopre_vec1", 32'(cpu_vector), 32'o060);
    cpu_int_ack = 1'b1;
    cyc(1);
    lit("nopre_ack", 32'(dev_int_ack), 32'b0010);
    cpu_int_ack = 1'b0;
    dev_int[1] = 1'b0;
    cyc(1);
    lit("nopre_hold_vec", 32'(cpu_vector), 32'o060);
    cyc(1);
    lit("nopre_idle_vec", 32'(cpu_vector), 32'd0);
    cyc(1);
    lit("nopre_new_vec", 32'(cpu_vector), 32'o064);
    lit("nopre_new_ipl", 32'(cpu_int_ipl), 32'd7);

    // reset during ACK cuts the pulse
    cpu_int_ack = 1'b1;
    cyc(1);
    lit("rstack_pulse", 32'(dev_int_ack), 32'b0100);
    cpu_int_ack = 1'b0;
    reset = 1'b0;
    cyc(1);
    lit("rstack_ack", 32'(dev_int_ack), 32'd0);
    lit("rstack_int", 32'(cpu_int), 32'd0);
    lit("rstack_vec", 32'(cpu_vector), 32'd0);
    lit("rstack_ipl", 32'(cpu_int_ipl), 32'd0);
    dev_int = '0;
    reset = 1'b1;
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
